// File: rtl/axi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_arbiter
// Brief    : Round-robin sharing of the AXI master line port among N_REQ
//            requesters, one transaction at a time, with timeout completion.
// Revision : 1.0 - initial release
// ============================================================================
module axi_master_arbiter #(
    parameter int N_REQ      = 2,
    parameter int TIMEOUT    = 1023,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            we_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [N_REQ*LINE_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic                        err_o,
    output logic [LINE_WIDTH-1:0]       rdata_o,
    output logic [1:0]                  gnt_id_o,
    output logic                        busy_o,
    output logic [ADDR_WIDTH-1:0]       m_addr_o,
    output logic [LINE_WIDTH-1:0]       m_wdata_o,
    output logic                        m_we_o,
    output logic                        m_cs_o,
    input  logic [LINE_WIDTH-1:0]       m_rdata_i,
    input  logic                        m_rvalid_i,
    input  logic                        m_wdone_i
);

    localparam int         c_cnt_w    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(TIMEOUT);
    localparam logic [1:0] c_last_rst = 2'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT_R = 3'd2,
        WAIT_B = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_last_gnt;
    logic [1:0]            r_gnt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_err;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_we;

    logic                  w_any;
    logic [1:0]            w_win;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LINE_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_we;
    logic                  w_timeout;
    logic [N_REQ-1:0]      w_ack;

    // Scan from lowest to highest priority so the requester closest after
    // last_gnt is the final (winning) assignment.
    always_comb begin
        w_any       = |req_i;
        w_win       = 2'd0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int j = N_REQ; j >= 1; j--) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_i[k] && (k == (int'(r_last_gnt) + j) % N_REQ)) begin
                    w_win       = 2'(k);
                    w_sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    w_sel_wdata = wdata_i[k*LINE_WIDTH +: LINE_WIDTH];
                    w_sel_we    = we_i[k];
                end
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_timeout);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = r_we ? WAIT_B : WAIT_R;
            WAIT_R:  if (m_rvalid_i || w_timeout) w_next = DONE;
            WAIT_B:  if (m_wdone_i || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_gnt <= c_last_rst;
            r_gnt      <= 2'd0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_we    <= w_sel_we;
                    end
                end
                ISSUE: begin
                    r_last_gnt <= r_gnt;
                    r_cnt      <= '0;
                end
                // Completion takes precedence over a coincident timeout.
                WAIT_R: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (m_rvalid_i) begin
                        r_rdata <= m_rdata_i;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                WAIT_B: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (m_wdone_i) begin
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ack = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_ack[k] = (r_state == DONE) && (r_gnt == 2'(k));
        end
    end

    assign ack_o     = w_ack;
    assign err_o     = (r_state == DONE) && r_err;
    assign rdata_o   = r_rdata;
    assign gnt_id_o  = r_gnt;
    assign busy_o    = (r_state != IDLE);
    assign m_addr_o  = r_addr;
    assign m_wdata_o = r_wdata;
    assign m_we_o    = r_we;
    assign m_cs_o    = (r_state == ISSUE);

endmodule
`default_nettype wire
